// File: rtl/ascon_cmd_sequencer.sv
// Turns a stream of instruction/data words into Ascon core key/bdi transfers with
// type and end-of-type/end-of-input framing, and optionally checks bdo/auth results.
module ascon_cmd_sequencer #(
   parameter int CCW      = 32,
   parameter int CCSW     = 32,
   parameter int CHECK_EN = 1,
   parameter int CNTW     = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_hdr,
   input  logic [CCW-1:0]  cmd_data,
   output logic [CCSW-1:0] key,
   output logic            key_valid,
   input  logic            key_ready,
   output logic [CCW-1:0]  bdi,
   output logic            bdi_valid,
   input  logic            bdi_ready,
   output logic [3:0]      bdi_type,
   output logic            bdi_eot,
   output logic            bdi_eoi,
   output logic            decrypt,
   output logic            hash,
   input  logic [CCW-1:0]  bdo,
   input  logic            bdo_valid,
   output logic            bdo_ready,
   input  logic [3:0]      bdo_type,
   input  logic            bdo_eot,
   input  logic            auth,
   input  logic            auth_valid,
   output logic            auth_ready,
   input  logic [CCW-1:0]  exp_data,
   input  logic            exp_valid,
   output logic            exp_ready,
   output logic [CNTW-1:0] out_cnt,
   output logic [CNTW-1:0] err_cnt,
   output logic            busy
);
   localparam int BPW = CCW / 8;
   localparam int SH  = $clog2(BPW);

   localparam logic [3:0] OP_DO_ENC   = 4'h2;
   localparam logic [3:0] OP_DO_DEC   = 4'h3;
   localparam logic [3:0] OP_LD_KEY   = 4'h4;
   localparam logic [3:0] OP_LD_NONCE = 4'h5;
   localparam logic [3:0] OP_LD_AD    = 4'h6;
   localparam logic [3:0] OP_LD_PT    = 4'h7;
   localparam logic [3:0] OP_DO_HASH  = 4'h8;
   localparam logic [3:0] OP_LD_CT    = 4'h9;
   localparam logic [3:0] OP_LD_TAG   = 4'hA;

   localparam logic [3:0] D_NULL  = 4'd0;
   localparam logic [3:0] D_NONCE = 4'd1;
   localparam logic [3:0] D_AD    = 4'd2;
   localparam logic [3:0] D_PTCT  = 4'd3;
   localparam logic [3:0] D_TAG   = 4'd4;

   typedef enum logic [1:0] {IDLE, LOAD, NULLB} state_t;

   state_t      state;
   logic [3:0]  op_reg;
   logic        last_reg;
   logic [23:0] remaining;
   logic        exp_auth;

   logic [3:0]  ins_op;
   logic [3:0]  ins_flags;
   logic        ins_legal;
   logic [24:0] len_sum;
   logic [23:0] rem_calc;
   logic        is_key;
   logic        beat_fire;
   logic        bdo_fire;
   logic        cmd_err;
   logic        bdo_err;
   logic        auth_err;
   logic [1:0]  err_inc;
   logic [CNTW+1:0] err_sum;
   logic [CNTW-1:0] err_sat;
   logic        unused_inputs;

   assign ins_op    = cmd_data[31:28];
   assign ins_flags = cmd_data[27:24];
   assign len_sum   = {1'b0, cmd_data[23:0]} + 25'(BPW - 1);
   assign rem_calc  = 24'(len_sum >> SH);
   assign is_key    = (op_reg == OP_LD_KEY);

   always_comb begin
      case (ins_op)
         OP_DO_ENC, OP_DO_DEC, OP_DO_HASH, OP_LD_KEY, OP_LD_NONCE,
         OP_LD_AD, OP_LD_PT, OP_LD_CT, OP_LD_TAG: ins_legal = 1'b1;
         default:                                  ins_legal = 1'b0;
      endcase
   end

   // Handshake and framing outputs are combinational so a LOAD beat costs no extra cycle.
   always_comb begin
      cmd_ready = 1'b0;
      key_valid = 1'b0;
      bdi_valid = 1'b0;
      bdi       = '0;
      bdi_type  = D_NULL;
      bdi_eot   = 1'b0;
      bdi_eoi   = 1'b0;
      case (state)
         IDLE: cmd_ready = 1'b1;
         LOAD: begin
            cmd_ready = cmd_hdr ? (is_key ? key_ready : bdi_ready) : 1'b1;
            key_valid = is_key & cmd_valid & cmd_hdr;
            bdi_valid = ~is_key & cmd_valid & cmd_hdr;
            bdi       = cmd_data;
            bdi_eot   = (remaining == 24'd1);
            bdi_eoi   = (remaining == 24'd1) & last_reg;
            case (op_reg)
               OP_LD_NONCE:        bdi_type = D_NONCE;
               OP_LD_AD:           bdi_type = D_AD;
               OP_LD_PT, OP_LD_CT: bdi_type = D_PTCT;
               OP_LD_TAG:          bdi_type = D_TAG;
               default:            bdi_type = D_NULL;
            endcase
         end
         NULLB: begin
            bdi_valid = 1'b1;
            bdi_eot   = 1'b1;
            bdi_eoi   = 1'b1;
         end
         default: ;
      endcase
      if (rst) begin
         cmd_ready = 1'b0;
         key_valid = 1'b0;
         bdi_valid = 1'b0;
      end
   end

   assign key        = cmd_data[CCSW-1:0];
   assign bdo_ready  = ~rst & ((CHECK_EN != 0) ? exp_valid : 1'b1);
   assign exp_ready  = ~rst & ((CHECK_EN != 0) ? bdo_valid : 1'b0);
   assign auth_ready = ~rst;
   assign busy       = (state != IDLE);

   assign beat_fire = (state == LOAD) & cmd_valid & cmd_hdr & (is_key ? key_ready : bdi_ready);
   assign bdo_fire  = bdo_valid & bdo_ready;
   assign cmd_err   = cmd_valid & (((state == IDLE) & (cmd_hdr | ~ins_legal)) |
                                   ((state == LOAD) & ~cmd_hdr));
   assign bdo_err   = (CHECK_EN != 0) & bdo_fire & (bdo != exp_data);
   assign auth_err  = (CHECK_EN != 0) & auth_valid & (auth != exp_auth);
   assign err_inc   = {1'b0, cmd_err} + {1'b0, bdo_err} + {1'b0, auth_err};
   assign err_sum   = {2'b00, err_cnt} + (CNTW+2)'(err_inc);
   assign err_sat   = (err_sum[CNTW+1:CNTW] != 2'b00) ? '1 : err_sum[CNTW-1:0];

   assign unused_inputs = ^{bdo_type, bdo_eot, ins_flags[3:2]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_reg    <= 4'h0;
         last_reg  <= 1'b0;
         remaining <= '0;
         exp_auth  <= 1'b0;
         decrypt   <= 1'b0;
         hash      <= 1'b0;
         out_cnt   <= '0;
         err_cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid && !cmd_hdr) begin
               case (ins_op)
                  OP_DO_ENC:  begin decrypt <= 1'b0; hash <= 1'b0; end
                  OP_DO_DEC:  begin decrypt <= 1'b1; hash <= 1'b0; end
                  OP_DO_HASH: begin decrypt <= 1'b0; hash <= 1'b1; end
                  OP_LD_KEY, OP_LD_NONCE, OP_LD_AD, OP_LD_PT, OP_LD_CT, OP_LD_TAG: begin
                     op_reg    <= ins_op;
                     last_reg  <= ins_flags[0];
                     remaining <= rem_calc;
                     if (ins_op == OP_LD_TAG)
                        exp_auth <= ins_flags[1];
                     if (rem_calc != 24'd0)
                        state <= LOAD;
                     else if (ins_flags[0])
                        state <= NULLB;
                  end
                  default: ;
               endcase
            end
            LOAD: if (beat_fire) begin
               remaining <= remaining - 24'd1;
               if (remaining == 24'd1)
                  state <= IDLE;
            end
            NULLB: if (bdi_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (bdo_fire && out_cnt != '1)
            out_cnt <= out_cnt + 1'b1;
         err_cnt <= err_sat;
      end
   end
endmodule

// File: tb/tb_ascon_cmd_sequencer.sv
// Directed bench for ascon_cmd_sequencer: a per-cycle vector table for the framing
// logic, then hand-written sequences for checking, counters, reset and a 64-bit variant.
module tb_ascon_cmd_sequencer;
   localparam logic [3:0] D_NULL = 4'd0;
   localparam logic [3:0] D_PTCT = 4'd3;
   localparam logic [3:0] D_TAG  = 4'd4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 32-bit checking instance
   logic cmd_valid = 0, cmd_ready, cmd_hdr = 0;
   logic [31:0] cmd_data = '0, key, bdi, bdo = '0, exp_data = '0;
   logic key_valid, key_ready = 0, bdi_valid, bdi_ready = 0, bdi_eot, bdi_eoi;
   logic [3:0] bdi_type;
   logic decrypt, hash, bdo_valid = 0, bdo_ready, auth = 0, auth_valid = 0, auth_ready;
   logic exp_valid = 0, exp_ready, busy;
   logic [15:0] out_cnt, err_cnt;

   ascon_cmd_sequencer #(.CCW(32), .CCSW(32), .CHECK_EN(1), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_hdr(cmd_hdr),
      .cmd_data(cmd_data), .key(key), .key_valid(key_valid), .key_ready(key_ready),
      .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .bdi_type(bdi_type),
      .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi), .decrypt(decrypt), .hash(hash), .bdo(bdo),
      .bdo_valid(bdo_valid), .bdo_ready(bdo_ready), .bdo_type(4'd3), .bdo_eot(1'b0),
      .auth(auth), .auth_valid(auth_valid), .auth_ready(auth_ready), .exp_data(exp_data),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .out_cnt(out_cnt), .err_cnt(err_cnt),
      .busy(busy));

   // 64-bit, unchecked instance with 2-bit counters to reach saturation quickly
   logic w_cmd_valid = 0, w_cmd_ready, w_cmd_hdr = 0;
   logic [63:0] w_cmd_data = '0, w_bdi;
   logic [31:0] w_key;
   logic w_key_valid, w_bdi_valid, w_bdi_ready = 0, w_bdi_eot, w_bdi_eoi;
   logic [3:0] w_bdi_type;
   logic w_decrypt, w_hash, w_bdo_valid = 0, w_bdo_ready, w_auth_valid = 0, w_auth_ready;
   logic w_exp_ready, w_busy;
   logic [1:0] w_out_cnt, w_err_cnt;

   ascon_cmd_sequencer #(.CCW(64), .CCSW(32), .CHECK_EN(0), .CNTW(2)) dut_w (
      .clk(clk), .rst(rst), .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready),
      .cmd_hdr(w_cmd_hdr), .cmd_data(w_cmd_data), .key(w_key), .key_valid(w_key_valid),
      .key_ready(1'b1), .bdi(w_bdi), .bdi_valid(w_bdi_valid), .bdi_ready(w_bdi_ready),
      .bdi_type(w_bdi_type), .bdi_eot(w_bdi_eot), .bdi_eoi(w_bdi_eoi), .decrypt(w_decrypt),
      .hash(w_hash), .bdo(64'h1), .bdo_valid(w_bdo_valid), .bdo_ready(w_bdo_ready),
      .bdo_type(4'd0), .bdo_eot(1'b0), .auth(1'b0), .auth_valid(w_auth_valid),
      .auth_ready(w_auth_ready), .exp_data(64'h2), .exp_valid(1'b0), .exp_ready(w_exp_ready),
      .out_cnt(w_out_cnt), .err_cnt(w_err_cnt), .busy(w_busy));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic v; logic hdr; logic [31:0] data; logic kr; logic br;
      logic cr; logic kv; logic bv; logic [3:0] ty; logic eot; logic eoi;
      logic bsy; logic dec; logic hsh; logic [15:0] err;
   } vec_t;

   vec_t tbl [0:28];

   initial begin
      //          v  hdr data          kr br   cr kv bv ty      eot eoi bsy dec hsh err
      tbl[0]  = '{0, 0, 32'h0,        1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 32'h40000010, 1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 1, 32'hA0A0A0A0, 1, 0,   1, 1, 0, D_NULL, 0, 0, 1, 0, 0, 0};
      tbl[3]  = '{1, 1, 32'hB1B1B1B1, 0, 1,   0, 1, 0, D_NULL, 0, 0, 1, 0, 0, 0};
      tbl[4]  = '{1, 1, 32'hB1B1B1B1, 0, 1,   0, 1, 0, D_NULL, 0, 0, 1, 0, 0, 0};
      tbl[5]  = '{1, 1, 32'hB1B1B1B1, 0, 1,   0, 1, 0, D_NULL, 0, 0, 1, 0, 0, 0};
      tbl[6]  = '{1, 1, 32'hB1B1B1B1, 1, 0,   1, 1, 0, D_NULL, 0, 0, 1, 0, 0, 0};
      tbl[7]  = '{1, 1, 32'hC2C2C2C2, 1, 0,   1, 1, 0, D_NULL, 0, 0, 1, 0, 0, 0};
      tbl[8]  = '{1, 1, 32'hD3D3D3D3, 1, 0,   1, 1, 0, D_NULL, 1, 0, 1, 0, 0, 0};
      tbl[9]  = '{0, 0, 32'h0,        1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[10] = '{1, 0, 32'h71000005, 1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[11] = '{1, 1, 32'h11111111, 0, 1,   1, 0, 1, D_PTCT, 0, 0, 1, 0, 0, 0};
      tbl[12] = '{1, 1, 32'h22222222, 1, 0,   0, 0, 1, D_PTCT, 1, 1, 1, 0, 0, 0};
      tbl[13] = '{1, 1, 32'h22222222, 0, 1,   1, 0, 1, D_PTCT, 1, 1, 1, 0, 0, 0};
      tbl[14] = '{0, 0, 32'h0,        1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[15] = '{1, 0, 32'h61000000, 1, 0,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[16] = '{1, 1, 32'h55555555, 1, 0,   0, 0, 1, D_NULL, 1, 1, 1, 0, 0, 0};
      tbl[17] = '{1, 1, 32'h55555555, 1, 1,   0, 0, 1, D_NULL, 1, 1, 1, 0, 0, 0};
      tbl[18] = '{0, 0, 32'h0,        1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[19] = '{1, 0, 32'h60000000, 1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[20] = '{0, 0, 32'h0,        1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[21] = '{1, 0, 32'h30000000, 1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[22] = '{0, 0, 32'h0,        1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 1, 0, 0};
      tbl[23] = '{1, 0, 32'h80000000, 1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 1, 0, 0};
      tbl[24] = '{0, 0, 32'h0,        1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 1, 0};
      tbl[25] = '{1, 0, 32'h20000000, 1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 1, 0};
      tbl[26] = '{0, 0, 32'h0,        1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[27] = '{1, 0, 32'hF0000000, 1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 0};
      tbl[28] = '{0, 0, 32'h0,        1, 1,   1, 0, 0, D_NULL, 0, 0, 0, 0, 0, 1};

      // Valid/ready outputs held low while in reset
      tick();
      exp_valid = 1;
      #1;
      chk("rst cmd_ready", cmd_ready, 0);
      chk("rst auth_ready", auth_ready, 0);
      chk("rst bdo_ready", bdo_ready, 0);
      exp_valid = 0;
      tick();
      rst = 0;

      for (int i = 0; i < 29; i++) begin
         cmd_valid = tbl[i].v; cmd_hdr = tbl[i].hdr; cmd_data = tbl[i].data;
         key_ready = tbl[i].kr; bdi_ready = tbl[i].br;
         #2;
         chk($sformatf("v%0d cmd_ready", i), cmd_ready, tbl[i].cr);
         chk($sformatf("v%0d key_valid", i), key_valid, tbl[i].kv);
         chk($sformatf("v%0d bdi_valid", i), bdi_valid, tbl[i].bv);
         chk($sformatf("v%0d bdi_type", i), bdi_type, tbl[i].ty);
         chk($sformatf("v%0d bdi_eot", i), bdi_eot, tbl[i].eot);
         chk($sformatf("v%0d bdi_eoi", i), bdi_eoi, tbl[i].eoi);
         chk($sformatf("v%0d busy", i), busy, tbl[i].bsy);
         chk($sformatf("v%0d decrypt", i), decrypt, tbl[i].dec);
         chk($sformatf("v%0d hash", i), hash, tbl[i].hsh);
         chk($sformatf("v%0d err_cnt", i), err_cnt, tbl[i].err);
         if (tbl[i].kv) chk($sformatf("v%0d key", i), key, tbl[i].data);
         if (tbl[i].bv) chk($sformatf("v%0d bdi", i), bdi, (tbl[i].ty == D_NULL) ? 32'h0 : tbl[i].data);
         $display("[TB] vector %0d applied", i);
         tick();
      end
      cmd_valid = 0; key_ready = 0; bdi_ready = 0;

      // Reset clears counters
      rst = 1; tick(); rst = 0; #1;
      chk("post-rst err_cnt", err_cnt, 0);
      chk("post-rst out_cnt", out_cnt, 0);

      // bdo checking against expected stream
      bdo_valid = 1; bdo = 32'hDEADBEEF; exp_valid = 0; #1;
      chk("bdo_ready no exp", bdo_ready, 0);
      chk("exp_ready follows bdo_valid", exp_ready, 1);
      tick();
      chk("no handshake out_cnt", out_cnt, 0);
      exp_valid = 1; exp_data = 32'hDEADBEEF; #1;
      chk("bdo_ready with exp", bdo_ready, 1);
      tick();
      chk("match out_cnt", out_cnt, 1);
      chk("match err_cnt", err_cnt, 0);
      exp_data = 32'hDEADBEEE;
      tick();
      chk("mismatch out_cnt", out_cnt, 2);
      chk("mismatch err_cnt", err_cnt, 1);
      bdo_valid = 0; exp_valid = 0;
      $display("[TB] bdo check sequence done");

      // Tag load with expected auth=1
      cmd_valid = 1; cmd_hdr = 0; cmd_data = 32'hA2000010; bdi_ready = 1;
      tick();
      for (int k = 0; k < 4; k++) begin
         cmd_hdr = 1; cmd_data = 32'h70000000 + k; #1;
         chk($sformatf("tag beat%0d type", k), bdi_type, D_TAG);
         chk($sformatf("tag beat%0d eot", k), bdi_eot, (k == 3));
         tick();
      end
      cmd_valid = 0;
      chk("tag busy after", busy, 0);
      auth_valid = 1; auth = 0;
      tick();
      chk("auth bad err_cnt", err_cnt, 2);
      auth = 1;
      tick();
      chk("auth good err_cnt", err_cnt, 2);
      auth_valid = 0;
      $display("[TB] tag/auth sequence done");

      // INS word inside LOAD is swallowed as an error
      cmd_valid = 1; cmd_hdr = 0; cmd_data = 32'h60000008;
      tick();
      cmd_data = 32'h30000000; #1;
      chk("ins-in-load cmd_ready", cmd_ready, 1);
      chk("ins-in-load bdi_valid", bdi_valid, 0);
      tick();
      chk("ins-in-load err_cnt", err_cnt, 3);
      chk("ins-in-load busy", busy, 1);
      chk("ins-in-load decrypt", decrypt, 0);
      cmd_hdr = 1; cmd_data = 32'h1; tick(); tick();
      cmd_valid = 0;
      chk("ins-in-load done", busy, 0);
      $display("[TB] ins-in-load sequence done");

      // Reset in the middle of a LOAD after DO_DEC
      cmd_valid = 1; cmd_hdr = 0; cmd_data = 32'h30000000; tick();
      cmd_data = 32'h71000010; tick();
      cmd_hdr = 1; cmd_data = 32'h9; tick(); tick();
      chk("mid-load decrypt", decrypt, 1);
      chk("mid-load busy", busy, 1);
      rst = 1; #1;
      chk("in-rst cmd_ready", cmd_ready, 0);
      chk("in-rst bdi_valid", bdi_valid, 0);
      tick();
      rst = 0; cmd_valid = 0; #1;
      chk("after-rst busy", busy, 0);
      chk("after-rst decrypt", decrypt, 0);
      chk("after-rst cmd_ready", cmd_ready, 1);
      chk("after-rst err_cnt", err_cnt, 0);
      chk("after-rst out_cnt", out_cnt, 0);
      $display("[TB] mid-load reset sequence done");

      // 64-bit unchecked instance: counters saturate, beats per length
      w_bdo_valid = 1; w_auth_valid = 1; #1;
      chk("w bdo_ready", w_bdo_ready, 1);
      chk("w exp_ready", w_exp_ready, 0);
      repeat (5) tick();
      w_bdo_valid = 0; w_auth_valid = 0;
      chk("w out_cnt sat", w_out_cnt, 3);
      chk("w err_cnt no check", w_err_cnt, 0);
      w_cmd_valid = 1; w_cmd_hdr = 1; w_cmd_data = 64'h5;
      repeat (5) tick();
      chk("w err_cnt sat", w_err_cnt, 3);
      w_cmd_hdr = 0; w_cmd_data = 64'h71000009; w_bdi_ready = 1; tick();
      w_cmd_hdr = 1; w_cmd_data = 64'h0123456789ABCDEF; #1;
      chk("w len9 beat0 eot", w_bdi_eot, 0);
      tick();
      w_cmd_data = 64'hFEDCBA9876543210; #1;
      chk("w len9 beat1 eot", w_bdi_eot, 1);
      chk("w len9 beat1 eoi", w_bdi_eoi, 1);
      chk("w len9 bdi", w_bdi, 64'hFEDCBA9876543210);
      tick();
      chk("w len9 done", w_busy, 0);
      w_cmd_hdr = 0; w_cmd_data = 64'h71000008; tick();
      w_cmd_hdr = 1; w_cmd_data = 64'h1; #1;
      chk("w len8 beat0 eot", w_bdi_eot, 1);
      chk("w len8 type", w_bdi_type, D_PTCT);
      tick();
      w_cmd_valid = 0;
      chk("w len8 done", w_busy, 0);
      $display("[TB] 64-bit sequence done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ascon_cmd_sequencer.md
Name: ascon_cmd_sequencer

Overview:
Synthesizable command sequencer that drives the Ascon core interface from a stream of instruction and data words. It decodes load and mode instructions, generates per-beat type, end-of-type and end-of-input framing, and tracks the persistent decrypt/hash mode. Optionally it checks bdo words and auth results against an expected-value stream and keeps output and error counters. It sits between a command source (FIFO, UART bridge or memory reader) and ascon_core, replacing file-driven stimulus for FPGA and side-channel measurement setups.

Parameters:
CCW, 32, bdi/bdo width in bits (32 or 64); BPW = CCW/8 bytes per word.
CCSW, 32, key width in bits; CCSW <= CCW; key = cmd_data[CCSW-1:0].
CHECK_EN, 1, 1 = compare bdo and auth against expected values; 0 = accept outputs unconditionally.
CNTW, 16, width of the out_cnt and err_cnt counters (saturating).

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  command word valid.
cmd_ready  out  1  command word accepted when cmd_valid & cmd_ready.
cmd_hdr  in  1  0 = INS word, 1 = DAT word.
cmd_data  in  CCW  INS: [31:28] op, [27:24] flags, [23:0] length in bytes; DAT: payload.
key  out  CCSW  key word to core.
key_valid / key_ready  out / in  1  key handshake.
bdi  out  CCW  block data to core.
bdi_valid / bdi_ready  out / in  1  bdi handshake.
bdi_type  out  4  D_NONCE/D_AD/D_PTCT/D_TAG/D_NULL.
bdi_eot  out  1  last word of current type.
bdi_eoi  out  1  last input word.
decrypt  out  1  registered mode bit.
hash  out  1  registered mode bit.
bdo  in  CCW  core output word.
bdo_valid / bdo_ready  in / out  1  bdo handshake.
bdo_type  in  4  type of bdo word.
bdo_eot  in  1  last bdo word of type.
auth / auth_valid  in  1 / 1  tag verification result.
auth_ready  out  1  always 1 when not in reset.
exp_data  in  CCW  expected bdo word.
exp_valid / exp_ready  in / out  1  expected-word handshake.
out_cnt  out  CNTW  bdo words accepted.
err_cnt  out  CNTW  mismatches plus illegal instructions.
busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; decrypt=0, hash=0; remaining count=0; out_cnt=0; err_cnt=0; exp_auth=0. All valid and ready outputs are 0 during reset. A reset mid-LOAD abandons the transfer; no partial state survives.
- States: IDLE, LOAD, NULLB.
- IDLE: cmd_ready=1. INS accept decodes op:
  - OP_DO_ENC sets decrypt=0, hash=0.
  - OP_DO_DEC sets decrypt=1, hash=0.
  - OP_DO_HASH sets decrypt=0, hash=1.
  - OP_LD_KEY/NONCE/AD/PT/CT/TAG latch op and flags; remaining = (len+BPW-1)/BPW. If remaining>0, go to LOAD. If len=0 and flags[0]=1, go to NULLB. If len=0 and flags[0]=0, stay in IDLE.
  - OP_LD_TAG also latches exp_auth=flags[1].
  - Any other op: err_cnt+1, stay in IDLE.
  - A DAT word received in IDLE: consumed, err_cnt+1.
- LOAD: outputs are combinational from cmd_data/cmd_valid; zero latency.
  - OP_LD_KEY: key_valid=cmd_valid&cmd_hdr; cmd_ready=key_ready.
  - Other ops: bdi_valid=cmd_valid&cmd_hdr; cmd_ready=bdi_ready; bdi_type per op (PT/CT map to D_PTCT).
  - bdi_eot=(remaining==1); bdi_eoi=bdi_eot&flags[0].
  - Each accepted beat decrements remaining; the beat at remaining==1 returns to IDLE.
  - An INS word received in LOAD is not forwarded: consumed, err_cnt+1, state stays LOAD.
- NULLB: one beat with bdi_valid=1, bdi_type=D_NULL, bdi_eot=1, bdi_eoi=1, bdi=0. No cmd word is consumed. Returns to IDLE on bdi_ready.
- Output checking:
  - CHECK_EN=0: bdo_ready=1, exp_ready=0.
  - CHECK_EN=1: bdo_ready=exp_valid; exp_ready=bdo_valid.
  - On bdo handshake: out_cnt+1; if CHECK_EN and bdo!=exp_data, err_cnt+1.
  - On auth_valid (CHECK_EN=1): auth!=exp_auth gives err_cnt+1.
- Simultaneous error events in one cycle add their sum to err_cnt. Both counters saturate at all-ones.

Test Plan:
- CCW=32, INS {OP_LD_KEY,0,16} + 4 DAT, key_ready low for cycles 2-4 -> exactly 4 key_valid handshakes, cmd_ready follows key_ready, no words lost, busy drops after 4th beat.
- INS {OP_LD_PT,flags=1,len=5} + 2 DAT -> 2 beats with bdi_type=D_PTCT; 2nd beat bdi_eot=1, bdi_eoi=1. With CCW=64, len=9 gives 2 beats, len=8 gives 1 beat.
- INS {OP_LD_AD,flags=1,len=0} -> one D_NULL beat with eot=eoi=1, no cmd consumed. With flags=0 -> no beat.
- CHECK_EN=1: bdo 0xDEADBEEF with exp 0xDEADBEEF -> out_cnt=1, err_cnt=0. Next exp 0xDEADBEEE -> err_cnt=1. exp_valid=0 -> bdo_ready=0.
- INS {OP_LD_TAG,flags=2,len=16}, core returns auth=0 -> err_cnt+1. auth=1 -> unchanged.
- OP_DO_DEC then rst pulse in LOAD after 2 of 4 words -> next cycle state=IDLE, decrypt=0, cmd_ready=1, counters 0.
